// File: rtl/udp_header_fifo.sv
// udp_header_fifo
//   First-word-fall-through buffer for packed UDP/IP/Ethernet header
//   descriptors. It holds up to DEPTH headers and uses valid/ready on both
//   sides. It can also drop headers whose UDP destination port does not match
//   cfg_port_match/cfg_port_mask (FILTER_EN), or whose IP protocol is not UDP
//   (PROTO_CHECK). A dropped header still completes its input handshake but is
//   not stored. drop_count counts dropped headers and saturates.
//
// Ports
//   clk, reset        system clock; synchronous active-high reset
//   s_hdr_*           input header stream (valid/ready/336-bit data)
//   m_hdr_*           output header stream (valid/ready/336-bit data)
//   cfg_port_match    destination port to accept
//   cfg_port_mask     per-bit compare enable for cfg_port_match
//   fill_count        number of headers currently stored
//   drop_count        headers discarded by the filter (saturating)
//
// Packed header layout, MSB first:
//   eth_dest_mac[335:288] eth_src_mac[287:240] eth_type[239:224]
//   ip_version[223:220] ip_ihl[219:216] ip_dscp[215:210] ip_ecn[209:208]
//   ip_length[207:192] ip_identification[191:176] ip_flags[175:173]
//   ip_fragment_offset[172:160] ip_ttl[159:152] ip_protocol[151:144]
//   ip_header_checksum[143:128] ip_source_ip[127:96] ip_dest_ip[95:64]
//   udp_source_port[63:48] udp_dest_port[47:32] udp_length[31:16]
//   udp_checksum[15:0]

module udp_header_fifo #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned FILTER_EN   = 0,
  parameter int unsigned PROTO_CHECK = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_hdr_valid,
  output logic                       s_hdr_ready,
  input  logic [335:0]               s_hdr_data,
  output logic                       m_hdr_valid,
  input  logic                       m_hdr_ready,
  output logic [335:0]               m_hdr_data,
  input  logic [15:0]                cfg_port_match,
  input  logic [15:0]                cfg_port_mask,
  output logic [$clog2(DEPTH+1)-1:0] fill_count,
  output logic [31:0]                drop_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [7:0]    IP_PROTO_UDP = 8'd17;

  logic [335:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [15:0] in_dest_port;
  logic [7:0]  in_protocol;
  logic        port_miss;
  logic        proto_miss;
  logic        drop;
  logic        accept;
  logic        do_write;
  logic        do_pop;
  logic        do_drop;

  assign in_dest_port = s_hdr_data[47:32];
  assign in_protocol  = s_hdr_data[151:144];

  // Ready is held low during reset so that a same-cycle handshake can never
  // complete from the producer's point of view.
  assign s_hdr_ready = !reset && (fill_count != FULL_COUNT);
  assign m_hdr_valid = (fill_count != '0);
  assign m_hdr_data  = mem[rd_ptr];

  always_comb begin
    port_miss  = ((in_dest_port ^ cfg_port_match) & cfg_port_mask) != '0;
    proto_miss = (in_protocol != IP_PROTO_UDP);
    drop       = ((FILTER_EN != 0) && port_miss) ||
                 ((PROTO_CHECK != 0) && proto_miss);
    accept     = s_hdr_valid && s_hdr_ready;
    do_write   = accept && !drop;
    do_drop    = accept && drop;
    do_pop     = m_hdr_valid && m_hdr_ready && !reset;
  end

  // Storage array is not reset; the pointers and count define which entries
  // are meaningful.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= s_hdr_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_count <= '0;
    end else begin
      case ({do_write, do_pop})
        2'b10:   fill_count <= fill_count + CW'(1);
        2'b01:   fill_count <= fill_count - CW'(1);
        default: fill_count <= fill_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (do_drop && (drop_count != '1)) begin
      drop_count <= drop_count + 32'd1;
    end
  end

endmodule
